// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants, state encoding and control resolution for hazard_ctrl
package hazard_ctrl_pkg;

  localparam logic       RESET       = 1'b1;
  localparam logic [1:0] WB_MEM      = 2'b01;
  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_ERR     = 2'b10
  } state_t;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  // Memory hold freezes everything; a taken branch discards the wrong-path load-use.
  function automatic ctrl_t resolve_ctrl(input logic mem_hold, input logic bj_taken,
                                         input logic load_use);
    ctrl_t c;
    c = '0;
    if (mem_hold) begin
      c.pc_stall    = 1'b1;
      c.ifid_stall  = 1'b1;
      c.idex_stall  = 1'b1;
      c.exmem_stall = 1'b1;
    end else if (bj_taken) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_stall   = 1'b1;
      c.ifid_stall = 1'b1;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, memory-wait FSM and stall/flush counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1Addr,
  input  logic [4:0]  id_rs2Addr,
  input  logic        id_useRs1,
  input  logic        id_useRs2,
  input  logic [4:0]  ex_rdAddr,
  input  logic        ex_rwen,
  input  logic [1:0]  ex_wbSel,
  input  logic        ex_bjTaken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pcStall,
  output logic        ifidStall,
  output logic        idexStall,
  output logic        exmemStall,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic [1:0]  state,
  output logic        memErr,
  output logic [15:0] stallCnt,
  output logic [15:0] flushCnt
);

  state_t      state_q;
  logic [7:0]  wait_cnt;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        load_use;
  logic        mem_hold;
  ctrl_t       ctrl;

  always_comb begin
    load_use = ex_rwen && (ex_wbSel == WB_MEM) && (ex_rdAddr != 5'd0) &&
               ((id_useRs1 && (id_rs1Addr == ex_rdAddr)) ||
                (id_useRs2 && (id_rs2Addr == ex_rdAddr)));
  end

  // The unused encoding 2'b11 falls into the RUN arm.
  always_comb begin
    mem_hold = 1'b0;
    case (state_q)
      ST_MEMWAIT: mem_hold = !mem_ready;
      ST_ERR:     mem_hold = 1'b1;
      default:    mem_hold = mem_req && !mem_ready;
    endcase
  end

  always_comb begin
    ctrl = resolve_ctrl(mem_hold, ex_bjTaken, load_use);
  end

  assign pcStall    = ctrl.pc_stall;
  assign ifidStall  = ctrl.ifid_stall;
  assign idexStall  = ctrl.idex_stall;
  assign exmemStall = ctrl.exmem_stall;
  assign ifidFlush  = ctrl.ifid_flush;
  assign idexFlush  = ctrl.idex_flush;

  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      state_q     <= ST_RUN;
      wait_cnt    <= 8'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        ST_MEMWAIT: begin
          if (!mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          // A completion in the timeout cycle still returns to RUN.
          if (mem_ready) begin
            state_q <= ST_RUN;
          end else if (wait_cnt == MEM_TIMEOUT - 8'd1) begin
            state_q <= ST_ERR;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          if (mem_req && !mem_ready) begin
            state_q  <= ST_MEMWAIT;
            wait_cnt <= 8'd0;
          end else begin
            state_q <= ST_RUN;
          end
        end
      endcase

      if (ctrl.pc_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (ctrl.ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign state    = state_q;
  assign memErr   = (state_q == ST_ERR);
  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;

endmodule
